// File: rtl/dbus_pkg.sv
// Shared definitions for the core data bus: RamMode bit positions, bus IDs,
// the captured request record, and the store lane-enable decoder.
package dbus_pkg;

    // RamMode bit positions, written {byte, half, word, unsigned}
    localparam int MODE_BYTE = 3;
    localparam int MODE_HALF = 2;
    localparam int MODE_WORD = 1;
    localparam int MODE_UNS  = 0;

    // Bus responder identifiers
    localparam int BUS_RAM  = 0;
    localparam int BUS_UART = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mode;
        logic        we;
        logic        re;
    } dbus_req_t;

    // Byte-lane enables for an access of the given size at byte offset off.
    // An illegal mode enables no lanes. Misalignment is checked by the caller.
    function automatic logic [3:0] dbus_lane_en(input logic [3:0] mode, input logic [1:0] off);
        logic [3:0] en;
        en = 4'b0000;
        unique case (mode[3:1])
            3'b100:  en = 4'b0001 << off;
            3'b010:  en = off[1] ? 4'b1100 : 4'b0011;
            3'b001:  en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/dbus_ram_responder_if.sv
// Load/store port between the core (master) and a data-bus responder (slave).
interface dbus_ram_responder_if;
    logic        clkEn;
    logic [31:0] addr;
    logic [31:0] dataBusOut;
    logic        wrEn;
    logic        rdEn;
    logic [3:0]  RamMode;
    logic [31:0] dataBusIn;
    logic        dataBusInEn;
    logic        hit;
    logic        err;

    modport master (
        output clkEn, addr, dataBusOut, wrEn, rdEn, RamMode,
        input  dataBusIn, dataBusInEn, hit, err
    );

    modport slave (
        input  clkEn, addr, dataBusOut, wrEn, rdEn, RamMode,
        output dataBusIn, dataBusInEn, hit, err
    );
endinterface

// File: rtl/dbus_bram_be.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, registered read.
module dbus_bram_be #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Lane-masked write and registered read on the same address
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dbus_ram_responder.sv
// RAM responder for the core load/store port. Three-stage flow:
// capture (N) -> array access (N+1) -> formatted result (N+2).
module dbus_ram_responder
    import dbus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    dbus_ram_responder_if.slave   bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);

    // Extract the addressed byte/half and extend it; word loads pass through.
    function automatic logic [31:0] format_load(input logic [31:0] raw,
                                                input logic [1:0]  off,
                                                input logic [3:0]  mode);
        logic [31:0]        shifted;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext;
        shifted = raw >> {off, 3'b000};
        b_s     = shifted[7:0];
        h_s     = off[1] ? raw[31:16] : raw[15:0];
        ext     = '0;
        if (mode[MODE_BYTE]) begin
            if (mode[MODE_UNS]) ext = {24'd0, b_s};
            else                ext = b_s;
        end else if (mode[MODE_HALF]) begin
            if (mode[MODE_UNS]) ext = {16'd0, h_s};
            else                ext = h_s;
        end else if (mode[MODE_WORD]) begin
            ext = raw;
        end
        return ext;
    endfunction

    // ---- stage p0: request from the core's EXE stage ----
    logic        accept_p0;
    logic [31:0] rel_p0;

    assign accept_p0 = bus.clkEn & (bus.wrEn | bus.rdEn);
    assign rel_p0    = bus.addr - BASE_ADDR;
    assign bus.hit   = accept_p0 & (rel_p0 < WIN_BYTES) & ~rst;

    dbus_req_t req_p1;
    logic      vld_p1;

    // S1 valid flag; clearing it on reset drops any store held in S1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept_p0;
    end

    // S1 payload capture
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            req_p1 <= '{addr:  bus.addr,
                        wdata: bus.dataBusOut,
                        mode:  bus.RamMode,
                        we:    bus.wrEn,
                        re:    bus.rdEn};
        end
    end

    // ---- stage p1: decode, drive the array ----
    logic [31:0]   rel_p1;
    logic [1:0]    off_p1;
    logic          in_win_p1;
    logic          mode_ok_p1;
    logic          misal_p1;
    logic          bad_p1;
    logic [3:0]    be_p1;
    logic          rd_p1;
    logic [31:0]   wdata_rep_p1;
    logic [AW-1:0] idx_p1;

    assign rel_p1     = req_p1.addr - BASE_ADDR;
    assign off_p1     = req_p1.addr[1:0];
    assign in_win_p1  = rel_p1 < WIN_BYTES;
    assign mode_ok_p1 = $onehot(req_p1.mode[3:1]);
    assign misal_p1   = (req_p1.mode[MODE_HALF] & off_p1[0]) |
                        (req_p1.mode[MODE_WORD] & (off_p1 != 2'b00));
    assign bad_p1     = ~in_win_p1 | ~mode_ok_p1 | misal_p1;
    assign idx_p1     = rel_p1[AW+1:2];

    // A store proceeds even when paired with a load; only access faults block it.
    assign be_p1 = (vld_p1 & req_p1.we & ~bad_p1) ? dbus_lane_en(req_p1.mode, off_p1) : 4'b0000;
    assign rd_p1 = vld_p1 & req_p1.re & ~req_p1.we & ~bad_p1;

    // Replicate store data so the selected lanes see it regardless of offset
    always_comb begin
        wdata_rep_p1 = req_p1.wdata;
        if (req_p1.mode[MODE_BYTE])      wdata_rep_p1 = {4{req_p1.wdata[7:0]}};
        else if (req_p1.mode[MODE_HALF]) wdata_rep_p1 = {2{req_p1.wdata[15:0]}};
    end

    logic [31:0] raw_p2;

    dbus_bram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
        .clk   (clk),
        .we    (be_p1),
        .re    (rd_p1),
        .addr  (idx_p1),
        .wdata (wdata_rep_p1),
        .rdata (raw_p2)
    );

    logic       vld_p2;
    logic       load_p2;
    logic       err_p2;
    logic [1:0] off_p2;
    logic [3:0] mode_p2;

    // S2 valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
    end

    // S2 payload: completion type, fault flag and formatting info
    always_ff @(posedge clk) begin
        load_p2 <= req_p1.re & ~req_p1.we;
        err_p2  <= bad_p1 | (req_p1.we & req_p1.re);
        off_p2  <= off_p1;
        mode_p2 <= req_p1.mode;
    end

    // ---- stage p2: result to the core's WB stage ----
    logic done_p2;

    assign done_p2         = vld_p2 & load_p2;
    assign bus.dataBusInEn = done_p2;
    assign bus.err         = vld_p2 & err_p2;
    assign bus.dataBusIn   = (done_p2 & ~err_p2) ? format_load(raw_p2, off_p2, mode_p2) : 32'd0;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Bench for dbus_ram_responder: directed scenarios plus random traffic against a
// byte-addressed reference memory.
module tb_dbus_ram_responder;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          DEPTH  = 64;
    localparam int          NBYTES = 4 * DEPTH;

    localparam logic [3:0] M_B  = 4'b1000;
    localparam logic [3:0] M_BU = 4'b1001;
    localparam logic [3:0] M_H  = 4'b0100;
    localparam logic [3:0] M_HU = 4'b0101;
    localparam logic [3:0] M_W  = 4'b0010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dbus_ram_responder_if bus();

    dbus_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [NBYTES];
    logic        pen  [2];
    logic        perr [2];
    logic [31:0] pdata[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.clkEn = 1'b0; bus.wrEn = 1'b0; bus.rdEn = 1'b0;
        bus.addr = 32'd0; bus.dataBusOut = 32'd0; bus.RamMode = 4'd0;
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 2; i++) begin
            pen[i] = 1'b0; perr[i] = 1'b0; pdata[i] = 32'd0;
        end
    endtask

    // One bus cycle: check results due now, present a request, predict its result.
    // drop=1 models a request that reset will flush before it takes effect.
    task automatic issue(input logic ce, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input bit drop);
        logic [31:0] rel, v;
        logic        in_win, legal, misal, bad, en_e, err_e;
        logic [31:0] data_e;
        int          size, ones;
        @(negedge clk);
        check("dataBusInEn", 32'(bus.dataBusInEn), 32'(pen[0]));
        check("err",         32'(bus.err),         32'(perr[0]));
        check("dataBusIn",   bus.dataBusIn,        pdata[0]);
        bus.clkEn = ce; bus.wrEn = we; bus.rdEn = re;
        bus.addr = a; bus.dataBusOut = d; bus.RamMode = m;
        #1;
        rel    = a - BASE;
        in_win = rel < 32'(NBYTES);
        check("hit", 32'(bus.hit), 32'(ce & (we | re) & in_win));
        ones   = int'(m[3]) + int'(m[2]) + int'(m[1]);
        legal  = (ones == 1);
        size   = m[3] ? 1 : (m[2] ? 2 : 4);
        misal  = legal && ((int'(a[1:0]) % size) != 0);
        bad    = !in_win || !legal || misal;
        en_e = 1'b0; err_e = 1'b0; data_e = 32'd0;
        if (ce && (we || re) && !drop) begin
            err_e = bad || (we && re);
            if (we && !bad)
                for (int i = 0; i < size; i++) ref_mem[int'(rel) + i] = d[8*i +: 8];
            if (re && !we) begin
                en_e = 1'b1;
                if (!bad) begin
                    v = 32'd0;
                    for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(rel) + i];
                    if (size < 4 && !m[0] && v[8*size-1])
                        v = v | ~((32'd1 << (8*size)) - 32'd1);
                    data_e = v;
                end
            end
        end
        pen[0] = pen[1]; perr[0] = perr[1]; pdata[0] = pdata[1];
        pen[1] = en_e;   perr[1] = err_e;   pdata[1] = data_e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},   32'(bus.dataBusInEn), 32'd0);
        check({tag, "_err"},  32'(bus.err),         32'd0);
        check({tag, "_data"}, bus.dataBusIn,        32'd0);
        check({tag, "_hit"},  32'(bus.hit),         32'd0);
    endtask

    logic [31:0] ra, rd;
    logic [3:0]  rm;
    logic        rwe, rre, rce;
    int          pick;

    initial begin
        rst = 1'b1;
        drive_idle();
        clear_pipe();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // Fill the whole array so every later load has a defined expectation
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 1'b1, 1'b0, BASE + 32'(4*w), $urandom, M_W, 1'b0);
        idle(2);

        // Word store followed immediately by a load of the same word
        issue(1'b1, 1'b1, 1'b0, 32'h10, 32'h8001_00FF, M_W, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h10, 32'd0,         M_W, 1'b0);
        idle(3);

        // Byte store, signed/unsigned byte loads, neighbouring bytes intact
        issue(1'b1, 1'b1, 1'b0, 32'h13, 32'h0000_00A5, M_B,  1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h13, 32'd0,         M_B,  1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h13, 32'd0,         M_BU, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h10, 32'd0,         M_W,  1'b0);
        idle(3);

        // Half store, signed/unsigned half loads, misaligned half load
        issue(1'b1, 1'b1, 1'b0, 32'h22, 32'h0000_8123, M_H,  1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h22, 32'd0,         M_H,  1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h22, 32'd0,         M_HU, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h21, 32'd0,         M_H,  1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h20, 32'd0,         M_W,  1'b0);
        idle(3);

        // Back-to-back word loads
        issue(1'b1, 1'b0, 1'b1, 32'h0, 32'd0, M_W, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h4, 32'd0, M_W, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h8, 32'd0, M_W, 1'b0);
        idle(3);

        // Out-of-window load and store, illegal mode, store+load collision
        issue(1'b1, 1'b0, 1'b1, BASE + 32'(NBYTES), 32'd0,         M_W,     1'b0);
        issue(1'b1, 1'b1, 1'b0, BASE + 32'(NBYTES), 32'hDEAD_BEEF, M_W,     1'b0);
        issue(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC,      32'hDEAD_BEEF, M_W,     1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h30,             32'd0,         4'b1100, 1'b0);
        issue(1'b1, 1'b1, 1'b1, 32'h34,             32'h1357_9BDF, M_W,     1'b0);
        issue(1'b1, 1'b0, 1'b1, 32'h34,             32'd0,         M_W,     1'b0);
        issue(1'b0, 1'b0, 1'b1, 32'h34,             32'd0,         M_W,     1'b0);
        idle(3);

        // Store caught by reset while in S1 must not reach the array
        issue(1'b1, 1'b1, 1'b0, 32'h38, 32'hCAFE_F00D, M_W, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        check_quiet("in_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        rst = 1'b0;
        clear_pipe();
        issue(1'b1, 1'b0, 1'b1, 32'h38, 32'd0, M_W, 1'b0);
        idle(3);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rce  = ($urandom_range(0, 7) != 0);
            pick = $urandom_range(0, 19);
            rwe  = (pick < 9) || (pick == 19);
            rre  = (pick >= 9);
            pick = $urandom_range(0, 19);
            case (pick % 6)
                0: rm = M_B;
                1: rm = M_BU;
                2: rm = M_H;
                3: rm = M_HU;
                4: rm = M_W;
                default: rm = (pick == 17) ? 4'($urandom) : M_W;
            endcase
            pick = $urandom_range(0, 19);
            if (pick < 17)       ra = BASE + 32'($urandom_range(0, NBYTES - 1));
            else if (pick < 19)  ra = BASE + 32'(NBYTES + $urandom_range(0, 31));
            else                 ra = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (rm[1])      ra[1:0] = 2'b00;
                else if (rm[2]) ra[0]   = 1'b0;
            end
            rd = $urandom;
            issue(rce, rwe, rre, ra, rd, rm, 1'b0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
